decode_pipe: RTL

DECODE_PIPE -- requirements
Module: decode_pipe

---
 rtl/decode_pkg.sv | 73 +++++++
 rtl/imm_gen.sv | 34 +++
 rtl/decode_pipe.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the RV32I decode pipeline.
//   - opcode constants for the RV32I base instruction groups
//   - alu_ctrl codes driven to the execute stage
//   - decoded-bundle field widths and the packed bundle type
//   - immediate format selector used by imm_gen
package decode_pkg;

   localparam int unsigned OPC_W  = 7;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned F3_W   = 3;
   localparam int unsigned F7_W   = 7;
   localparam int unsigned ALU_W  = 4;
   localparam int unsigned INSN_W = 32;

   localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
   localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
   localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
   localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
   localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

   localparam logic [ALU_W-1:0] ALU_AND   = 4'b0000;
   localparam logic [ALU_W-1:0] ALU_OR    = 4'b0001;
   localparam logic [ALU_W-1:0] ALU_ADD   = 4'b0010;
   localparam logic [ALU_W-1:0] ALU_XOR   = 4'b0011;
   localparam logic [ALU_W-1:0] ALU_SLL   = 4'b0100;
   localparam logic [ALU_W-1:0] ALU_SRL   = 4'b0101;
   localparam logic [ALU_W-1:0] ALU_SUB   = 4'b0110;
   localparam logic [ALU_W-1:0] ALU_SLT   = 4'b0111;
   localparam logic [ALU_W-1:0] ALU_SLTU  = 4'b1000;
   localparam logic [ALU_W-1:0] ALU_PASSB = 4'b1001;
   localparam logic [ALU_W-1:0] ALU_SRA   = 4'b1101;

   typedef enum logic [2:0] {
      IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
   } imm_fmt_t;

   typedef struct packed {
      logic [OPC_W-1:0] opcode;
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [F3_W-1:0]  funct3;
      logic [F7_W-1:0]  funct7;
      logic [ALU_W-1:0] alu_ctrl;
      logic             alu_src;
      logic             mem_read;
      logic             mem_write;
      logic             reg_write;
      logic             mem_to_reg;
      logic             branch;
      logic             jump;
      logic             illegal;
   } bundle_t;

   // funct3 -> ALU operation; alt selects SUB/SRA (funct7[5]) where it applies.
   function automatic logic [ALU_W-1:0] alu_from_f3(input logic [F3_W-1:0] f3, input logic alt);
      case (f3)
         3'd0:    return alt ? ALU_SUB : ALU_ADD;
         3'd1:    return ALU_SLL;
         3'd2:    return ALU_SLT;
         3'd3:    return ALU_SLTU;
         3'd4:    return ALU_XOR;
         3'd5:    return alt ? ALU_SRA : ALU_SRL;
         3'd6:    return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational immediate extraction for RV32I.
//   instr  in   32    raw instruction
//   fmt    in   enum  immediate format (I/S/B/U/J, NONE -> 0)
//   imm    out  XLEN  immediate, sign-extended from instr[31]
module imm_gen
   import decode_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [31:0]     instr,
   input  imm_fmt_t        fmt,
   output logic [XLEN-1:0] imm
);

   logic [31:0] imm32;
   logic        unused_opcode_bits;

   assign unused_opcode_bits = ^instr[6:0];

   always_comb begin
      imm32 = '0;
      case (fmt)
         IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm32 = {instr[31:12], 12'b0};
         IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   assign imm = XLEN'(signed'(imm32));

endmodule

// File: rtl/decode_pipe.sv
// decode_pipe: RV32I decode stage with valid/ready handshakes on both sides.
//   clk, rst (async, active-low)
//   in_valid/in_ready, in_instr[31:0], in_pc[PCW-1:0]  fetch side
//   flush                                              drop everything buffered/offered
//   out_valid/out_ready                                execute side
//   out_opcode/rd/rs1/rs2/funct3/funct7                raw instruction fields
//   out_imm[XLEN-1:0], out_pc[PCW-1:0]                 immediate, instruction address
//   out_alu_ctrl[3:0], out_alu_src, out_mem_read, out_mem_write, out_reg_write,
//   out_mem_to_reg, out_branch, out_jump, out_illegal  control bundle
// SKID=1 gives an output register plus a skid slot; SKID=0 a single entry.
module decode_pipe
   import decode_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned PCW  = 32,
   parameter int unsigned SKID = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [PCW-1:0]  in_pc,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [6:0]      out_opcode,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [2:0]      out_funct3,
   output logic [6:0]      out_funct7,
   output logic [XLEN-1:0] out_imm,
   output logic [PCW-1:0]  out_pc,
   output logic [3:0]      out_alu_ctrl,
   output logic            out_alu_src,
   output logic            out_mem_read,
   output logic            out_mem_write,
   output logic            out_reg_write,
   output logic            out_mem_to_reg,
   output logic            out_branch,
   output logic            out_jump,
   output logic            out_illegal
);

   typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

   state_t          state;
   logic            rdy_q;
   bundle_t         dec, out_b, skid_b;
   imm_fmt_t        fmt;
   logic [XLEN-1:0] dec_imm, out_imm_q, skid_imm;
   logic [PCW-1:0]  out_pc_q, skid_pc;
   logic            accept, drain;
   logic [2:0]      f3;
   logic [6:0]      f7;

   assign f3 = in_instr[14:12];
   assign f7 = in_instr[31:25];

   always_comb begin
      dec        = '0;
      fmt        = IMM_NONE;
      dec.opcode = in_instr[6:0];
      dec.rd     = in_instr[11:7];
      dec.rs1    = in_instr[19:15];
      dec.rs2    = in_instr[24:20];
      dec.funct3 = f3;
      dec.funct7 = f7;
      case (in_instr[6:0])
         OPC_LUI:    begin fmt = IMM_U; dec.alu_ctrl = ALU_PASSB; dec.alu_src = 1'b1; dec.reg_write = 1'b1; end
         OPC_AUIPC:  begin fmt = IMM_U; dec.alu_ctrl = ALU_ADD; dec.alu_src = 1'b1; dec.reg_write = 1'b1; end
         OPC_JAL:    begin fmt = IMM_J; dec.alu_ctrl = ALU_ADD; dec.jump = 1'b1; dec.reg_write = 1'b1; end
         OPC_JALR:   begin fmt = IMM_I; dec.alu_ctrl = ALU_ADD; dec.jump = 1'b1; dec.reg_write = 1'b1; end
         OPC_BRANCH: begin fmt = IMM_B; dec.alu_ctrl = ALU_SUB; dec.branch = 1'b1; end
         OPC_LOAD: begin
            fmt = IMM_I; dec.alu_ctrl = ALU_ADD; dec.alu_src = 1'b1;
            dec.mem_read = 1'b1; dec.mem_to_reg = 1'b1; dec.reg_write = 1'b1;
         end
         OPC_STORE:  begin fmt = IMM_S; dec.alu_ctrl = ALU_ADD; dec.alu_src = 1'b1; dec.mem_write = 1'b1; end
         OPC_OPIMM: begin
            // funct3=000 is ADDI regardless of the upper immediate bits.
            fmt = IMM_I;
            dec.alu_ctrl  = alu_from_f3(f3, (f3 == 3'd5) && f7[5]);
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
            dec.illegal   = ((f3 == 3'd1) && (f7 != 7'h00)) ||
                            ((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20));
         end
         OPC_OP: begin
            dec.alu_ctrl  = alu_from_f3(f3, f7[5]);
            dec.reg_write = 1'b1;
            dec.illegal   = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
         end
         default: dec.illegal = 1'b1;
      endcase
      if (dec.illegal) begin
         dec.alu_ctrl   = '0;
         dec.alu_src    = 1'b0;
         dec.mem_read   = 1'b0;
         dec.mem_write  = 1'b0;
         dec.reg_write  = 1'b0;
         dec.mem_to_reg = 1'b0;
         dec.branch     = 1'b0;
         dec.jump       = 1'b0;
      end
   end

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr (in_instr),
      .fmt   (fmt),
      .imm   (dec_imm)
   );

   assign out_valid = (state != ST_EMPTY);
   // Without a skid slot the single entry can be refilled in the cycle it drains.
   assign in_ready  = (SKID != 0) ? rdy_q : (rdy_q && (!out_valid || out_ready));
   assign accept    = in_valid && in_ready && !flush;
   assign drain     = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_EMPTY;
         rdy_q     <= 1'b0;
         out_b     <= '0;
         out_imm_q <= '0;
         out_pc_q  <= '0;
         skid_b    <= '0;
         skid_imm  <= '0;
         skid_pc   <= '0;
      end else if (flush) begin
         state <= ST_EMPTY;
         rdy_q <= 1'b1;
      end else begin
         rdy_q <= 1'b1;
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  out_b <= dec; out_imm_q <= dec_imm; out_pc_q <= in_pc;
                  state <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && drain) begin
                  out_b <= dec; out_imm_q <= dec_imm; out_pc_q <= in_pc;
               end else if (accept && (SKID != 0)) begin
                  skid_b <= dec; skid_imm <= dec_imm; skid_pc <= in_pc;
                  state  <= ST_TWO;
                  rdy_q  <= 1'b0;
               end else if (drain) begin
                  state <= ST_EMPTY;
               end
            end
            default: begin
               if (drain) begin
                  out_b <= skid_b; out_imm_q <= skid_imm; out_pc_q <= skid_pc;
                  state <= ST_ONE;
               end else begin
                  rdy_q <= 1'b0;
               end
            end
         endcase
      end
   end

   assign out_opcode     = out_b.opcode;
   assign out_rd         = out_b.rd;
   assign out_rs1        = out_b.rs1;
   assign out_rs2        = out_b.rs2;
   assign out_funct3     = out_b.funct3;
   assign out_funct7     = out_b.funct7;
   assign out_imm        = out_imm_q;
   assign out_pc         = out_pc_q;
   assign out_alu_ctrl   = out_b.alu_ctrl;
   assign out_alu_src    = out_b.alu_src;
   assign out_mem_read   = out_b.mem_read;
   assign out_mem_write  = out_b.mem_write;
   assign out_reg_write  = out_b.reg_write;
   assign out_mem_to_reg = out_b.mem_to_reg;
   assign out_branch     = out_b.branch;
   assign out_jump       = out_b.jump;
   assign out_illegal    = out_b.illegal;

endmodule
